muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Parametrised multi-cycle multiply/divide unit owning the HI/LO register pair. It sits beside the execute-stage ALU and replaces the single-cycle combinational multiplier. Iterative datapaths (radix-2^MUL_STEP_BITS multiply, radix-2 restoring divide) are sequenced by an FSM. A valid/ready handshake lets the pipeline stall while an operation runs, and a flush input lets exceptions abort in-flight work.

Parameters:
WIDTH, 32, operand width; hi/lo are each WIDTH bits.
MUL_STEP_BITS, 4, multiplier bits retired per cycle; WIDTH % MUL_STEP_BITS must be 0 (elaboration error otherwise).

Ports:
clk  input  1  clock, rising edge
resetn  input  1  asynchronous active-low reset
op_valid  input  1  operation request
op_ready  output  1  unit can accept (state IDLE)
op  input  3  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved
in1  input  WIDTH  rs value (multiplicand / dividend / MTHI/MTLO source)
in2  input  WIDTH  rt value (multiplier / divisor)
flush  input  1  abort in-flight op, block acceptance this cycle
busy  output  1  MUL or DIV iteration in progress
done  output  1  one-cycle pulse: hi/lo just updated by a MUL/DIV/MT op
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (resetn low, async): hi=0, lo=0, busy=0, done=0, FSM=IDLE, iteration counter=0. Reset wins over every other input.
- States: IDLE, MUL, DIV. op_ready = (state==IDLE). busy = (state!=IDLE). Accept = op_valid & op_ready & !flush.
- Op 0 and op 7 on accept: no state change, no done.
- MTHI/MTLO on accept: hi (resp. lo) <= in1 at that edge; done=1 the following cycle; FSM stays IDLE.
- MULT/MULTU on accept: operands captured. Signed op uses magnitudes, and the product is negated at write-back if the signs differ. FSM->MUL for N_MUL = WIDTH/MUL_STEP_BITS cycles. At the N_MUL-th edge after the accept edge: {hi,lo} <= 2*WIDTH-bit product, FSM->IDLE, done=1 for that cycle.
- DIV/DIVU on accept: FSM->DIV for N_DIV = WIDTH cycles, one quotient bit per cycle. At the N_DIV-th edge: lo <= quotient, hi <= remainder, FSM->IDLE, done=1.
- Signed divide: quotient truncates toward zero; remainder takes the sign of the dividend.
- Divide by zero (either signedness): lo = all ones, hi = in1. Same latency, no exception.
- Signed overflow (in1 = most-negative, in2 = -1): lo = in1, hi = 0.
- op_valid while busy: ignored (op_ready=0); the producer holds op and operands stable until accepted.
- flush while busy: at next edge FSM->IDLE, counter cleared, hi/lo unchanged, no done. flush with op_valid in IDLE: op not accepted.
- flush on the cycle whose edge would write back: flush wins; there is no write and no done.
- hi/lo are registered outputs only. There is no bypass of in-flight results; consumers stall on busy.
- done is never asserted while busy=1. After a MUL/DIV, op_ready is high in the same cycle done is high, so back-to-back ops are accepted with zero bubble.

Test Plan:
- MULTU in1=0xFFFFFFFF in2=0xFFFFFFFF -> busy for 8 cycles; 8th edge: hi=0xFFFFFFFE, lo=0x00000001, done 1 cycle.
- MULT in1=0xFFFFFFFD(-3) in2=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB after 8 cycles.
- DIV in1=0xFFFFFFF9(-7) in2=2 -> after 32 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/0 -> lo=0xFFFFFFFF, hi=7.
- DIV in1=0x80000000 in2=0xFFFFFFFF -> lo=0x80000000, hi=0. Then MTHI in1=0x1234 -> hi=0x1234 next edge, done next cycle, busy never set.
- Start DIV with hi=lo=0x55; raise op_valid with a MULT at cycle 5 (must not be accepted); flush at cycle 10 -> busy=0 next cycle, hi=lo=0x55, no done. Then MULT 2*3 accepted -> lo=6, hi=0.
- Pull resetn low mid-MULT (cycle 4) -> hi=lo=0, busy=0, done=0 immediately without a clock edge. After release, op_ready=1 and a new op completes normally.

Source files
------------

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO pair: radix-2^MUL_STEP_BITS
// shift-add multiply and radix-2 restoring divide, sequenced by a small FSM.
module muldiv_unit #(
  parameter int WIDTH         = 32,
  parameter int MUL_STEP_BITS = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  generate
    if (WIDTH % MUL_STEP_BITS != 0) begin : g_bad_step
      $error("muldiv_unit: WIDTH must be a multiple of MUL_STEP_BITS");
    end
  endgenerate

  localparam int N_MUL = WIDTH / MUL_STEP_BITS;
  localparam int CW    = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] MUL_LAST = CW'(N_MUL - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc, mcand, mul_sum, mul_res;
  logic [WIDTH-1:0]   mplier, rem, quot, dsr, orig;
  logic               neg_res, neg_q, neg_r, div_zero;

  // Handshake: an op transfers on a rising edge where op_valid && op_ready && !flush;
  // the producer holds op/in1/in2 steady until then. op_ready is high only in IDLE.
  logic accept, signed_op, in1_neg, in2_neg;
  logic [WIDTH-1:0] abs1, abs2;

  assign op_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign accept    = op_valid & op_ready & ~flush;
  assign signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign in1_neg   = signed_op & in1[WIDTH-1];
  assign in2_neg   = signed_op & in2[WIDTH-1];
  assign abs1      = in1_neg ? -in1 : in1;
  assign abs2      = in2_neg ? -in2 : in2;

  // One multiplier digit per cycle: add the shifted multiplicand for each set bit.
  always_comb begin
    mul_sum = acc;
    for (int b = 0; b < MUL_STEP_BITS; b++) begin
      if (mplier[b]) mul_sum = mul_sum + (mcand << b);
    end
    mul_res = neg_res ? -mul_sum : mul_sum;
  end

  logic [WIDTH:0]   rem_sh, diff;
  logic [WIDTH-1:0] q_next, r_next, q_fin, r_fin;

  // Restoring step: the borrow bit of the trial subtraction decides the quotient bit.
  always_comb begin
    rem_sh = {rem, quot[WIDTH-1]};
    diff   = rem_sh - {1'b0, dsr};
    q_next = {quot[WIDTH-2:0], ~diff[WIDTH]};
    r_next = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
    q_fin  = neg_q ? -q_next : q_next;
    r_fin  = neg_r ? -r_next : r_next;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      rem      <= '0;
      quot     <= '0;
      dsr      <= '0;
      orig     <= '0;
      neg_res  <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                acc     <= '0;
                mcand   <= {{WIDTH{1'b0}}, abs1};
                mplier  <= abs2;
                neg_res <= in1_neg ^ in2_neg;
                cnt     <= '0;
                state   <= S_MUL;
              end
              OP_DIV, OP_DIVU: begin
                rem      <= '0;
                quot     <= abs1;
                dsr      <= abs2;
                orig     <= in1;
                neg_q    <= in1_neg ^ in2_neg;
                neg_r    <= in1_neg;
                div_zero <= (in2 == '0);
                cnt      <= '0;
                state    <= S_DIV;
              end
              OP_MTHI: begin
                hi   <= in1;
                done <= 1'b1;
              end
              OP_MTLO: begin
                lo   <= in1;
                done <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        S_MUL: begin
          if (flush) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            acc    <= mul_sum;
            mcand  <= mcand << MUL_STEP_BITS;
            mplier <= mplier >> MUL_STEP_BITS;
            if (cnt == MUL_LAST) begin
              {hi, lo} <= mul_res;
              done     <= 1'b1;
              state    <= S_IDLE;
              cnt      <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_DIV: begin
          if (flush) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            rem  <= r_next;
            quot <= q_next;
            if (cnt == DIV_LAST) begin
              // Divide by zero leaves the dividend in HI and all ones in LO.
              if (div_zero) begin
                lo <= '1;
                hi <= orig;
              end else begin
                lo <= q_fin;
                hi <= r_fin;
              end
              done  <= 1'b1;
              state <= S_IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random ops
// checked against an arithmetic model of HI/LO.
module tb_muldiv_unit;

  logic        clk;
  logic        resetn;
  logic        op_valid;
  logic        op_ready;
  logic [2:0]  op;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [63:0] exp_q[$];

  muldiv_unit #(.WIDTH(32), .MUL_STEP_BITS(4)) dut (
    .clk(clk), .resetn(resetn), .op_valid(op_valid), .op_ready(op_ready),
    .op(op), .in1(in1), .in2(in2), .flush(flush), .busy(busy), .done(done),
    .hi(hi), .lo(lo)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: new {hi,lo} from the architectural rules.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] cur);
    logic signed [63:0] sa, sb;
    int qa, qb;
    case (o)
      3'd1: begin
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        return sa * sb;
      end
      3'd2: return {32'b0, a} * {32'b0, b};
      3'd3: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, a};
        qa = a;
        qb = b;
        return {32'(qa % qb), 32'(qa / qb)};
      end
      3'd4: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      3'd5: return {a, cur[31:0]};
      3'd6: return {cur[63:32], a};
      default: return cur;
    endcase
  endfunction

  // done must never coincide with busy
  always @(negedge clk) begin
    if (resetn && done) check("done_not_busy", {63'b0, busy}, 64'b0);
  end

  // Driver: starts and ends at a negedge; checks latency, done pulse and result.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int lat, bcnt, guard;
    logic [63:0] e;
    lat = (o == 3'd1 || o == 3'd2) ? 8 : (o == 3'd3 || o == 3'd4) ? 32 : 0;
    exp_q.push_back(model(o, a, b, {m_hi, m_lo}));
    check("ready_before", {63'b0, op_ready}, 64'd1);
    op_valid = 1'b1; op = o; in1 = a; in2 = b;
    @(negedge clk);
    op_valid = 1'b0;
    e = exp_q.pop_front();
    if (lat == 0) begin
      check("mt_done", {63'b0, done}, {63'b0, (o == 3'd5 || o == 3'd6)});
      check("mt_busy", {63'b0, busy}, 64'b0);
    end else begin
      bcnt = 0;
      guard = 0;
      while (!done && guard < lat + 20) begin
        if (busy) bcnt++;
        @(negedge clk);
        guard++;
      end
      check("done_seen", {63'b0, done}, 64'd1);
      check("latency", 64'(bcnt), 64'(lat));
      check("ready_at_done", {63'b0, op_ready}, 64'd1);
    end
    check($sformatf("hilo_op%0d", o), {hi, lo}, e);
    {m_hi, m_lo} = e;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    resetn = 1'b0; op_valid = 1'b0; op = '0; in1 = '0; in2 = '0; flush = 1'b0;
    #3;
    check("rst_hilo", {hi, lo}, 64'h0);
    check("rst_busy_done", {62'b0, busy, done}, 64'h0);
    check("rst_ready", {63'b0, op_ready}, 64'd1);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // directed cases
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(3'd1, 32'hFFFF_FFFD, 32'd7);
    issue(3'd3, 32'hFFFF_FFF9, 32'd2);
    issue(3'd4, 32'd7, 32'd0);
    issue(3'd3, 32'd7, 32'd0);
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(3'd5, 32'h1234, 32'h0);
    issue(3'd0, 32'hDEAD, 32'hBEEF);
    issue(3'd7, 32'hDEAD, 32'hBEEF);

    // flush mid-divide with a competing request while busy
    issue(3'd5, 32'h55, 32'h0);
    issue(3'd6, 32'h55, 32'h0);
    op_valid = 1'b1; op = 3'd3; in1 = 32'd100; in2 = 32'd7;
    @(negedge clk);
    op_valid = 1'b0;
    for (int c = 1; c < 10; c++) begin
      if (c == 5) begin
        op_valid = 1'b1; op = 3'd1; in1 = 32'd2; in2 = 32'd3;
      end
      if (c >= 5) check("ready_while_busy", {63'b0, op_ready}, 64'b0);
      check("no_done_in_div", {63'b0, done}, 64'b0);
      @(negedge clk);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; op_valid = 1'b0;
    check("flush_busy", {63'b0, busy}, 64'b0);
    check("flush_done", {63'b0, done}, 64'b0);
    check("flush_hilo", {hi, lo}, {m_hi, m_lo});
    @(negedge clk);
    check("flush_no_late_done", {63'b0, done}, 64'b0);
    issue(3'd1, 32'd2, 32'd3);

    // flush on the write-back edge
    op_valid = 1'b1; op = 3'd2; in1 = 32'd5; in2 = 32'd5;
    @(negedge clk);
    op_valid = 1'b0;
    repeat (7) @(negedge clk);
    check("busy_pre_wb", {63'b0, busy}, 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("wbflush_done", {63'b0, done}, 64'b0);
    check("wbflush_busy", {63'b0, busy}, 64'b0);
    check("wbflush_hilo", {hi, lo}, {m_hi, m_lo});

    // flush in IDLE blocks acceptance
    flush = 1'b1; op_valid = 1'b1; op = 3'd5; in1 = 32'hAAAA;
    @(negedge clk);
    flush = 1'b0; op_valid = 1'b0;
    check("idle_flush_busy_done", {62'b0, busy, done}, 64'b0);
    check("idle_flush_hilo", {hi, lo}, {m_hi, m_lo});

    // async reset mid-multiply
    op_valid = 1'b1; op = 3'd1; in1 = 32'h1234_5678; in2 = 32'h9ABC;
    @(negedge clk);
    op_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("arst_hilo", {hi, lo}, 64'h0);
    check("arst_busy_done", {62'b0, busy, done}, 64'h0);
    check("arst_ready", {63'b0, op_ready}, 64'd1);
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    issue(3'd2, 32'd1000, 32'd3000);

    // random back-to-back traffic
    for (int i = 0; i < 40; i++) begin
      issue(3'($urandom_range(0, 7)), pick(), pick());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
